// File: rtl/display_scan_controller_if.sv
// Load handshake bundle: a producer offers a 16-bit display value and the scan
// controller takes it when both load_valid and load_ready are high on a rising edge.
interface display_scan_controller_if;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_ready;

   modport master (output load_valid, output load_data, input load_ready);
   modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/display_scan_controller.sv
// 4-digit multiplexed 7-segment scanner: 16 phases of PRESCALE clocks per frame, digit k lit only in phase 4k+2.
// Outputs registered one clk after phase entry; one-deep load buffer holds load_ready low until the frame wraps.
module display_scan_controller #(
   parameter int unsigned PRESCALE = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          en,
   input  logic [3:0]                    blank,
   display_scan_controller_if.slave      load,
   output logic                          an0,
   output logic                          an1,
   output logic                          an2,
   output logic                          an3,
   output logic [6:0]                    seg,
   output logic                          frame_done
);

   localparam logic [15:0] LAST = 16'(PRESCALE - 1);

   logic [15:0] prescaler;
   logic [3:0]  phase;
   logic [15:0] active_val;
   logic [15:0] pending_val;
   logic        ready_q;
   logic [3:0]  an_q;
   logic [6:0]  seg_q;
   logic        frame_done_q;

   logic        tick;
   logic        wrap;
   logic        accept;
   logic [1:0]  digit;
   logic [3:0]  nibble;
   logic [6:0]  glyph;
   logic [3:0]  an_nxt;

   always_comb begin
      tick   = en && (prescaler == LAST);
      wrap   = tick && (phase == 4'hF);
      accept = load.load_valid && ready_q;
      digit  = phase[3:2];
      nibble = 4'h0;
      case (digit)
         2'd0:    nibble = active_val[3:0];
         2'd1:    nibble = active_val[7:4];
         2'd2:    nibble = active_val[11:8];
         default: nibble = active_val[15:12];
      endcase
   end

   // Active-low glyphs, bit order {g,f,e,d,c,b,a}
   always_comb begin
      glyph = 7'b1111111;
      case (nibble)
         4'h0: glyph = 7'b1000000;
         4'h1: glyph = 7'b1111001;
         4'h2: glyph = 7'b0100100;
         4'h3: glyph = 7'b0110000;
         4'h4: glyph = 7'b0011001;
         4'h5: glyph = 7'b0010010;
         4'h6: glyph = 7'b0000010;
         4'h7: glyph = 7'b1111000;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0010000;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b0000011;
         4'hC: glyph = 7'b1000110;
         4'hD: glyph = 7'b0100001;
         4'hE: glyph = 7'b0000110;
         4'hF: glyph = 7'b0001110;
         default: glyph = 7'b1111111;
      endcase
   end

   // Only the middle of each 4-phase digit slot lights the anode; the rest are ghosting guards.
   always_comb begin
      an_nxt = 4'hF;
      if (phase[1:0] == 2'd2 && !blank[digit]) begin
         an_nxt[digit] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prescaler    <= 16'h0000;
         phase        <= 4'h0;
         active_val   <= 16'h0000;
         pending_val  <= 16'h0000;
         ready_q      <= 1'b1;
         an_q         <= 4'hF;
         seg_q        <= 7'b1111111;
         frame_done_q <= 1'b0;
      end else begin
         if (tick) begin
            prescaler <= 16'h0000;
            phase     <= phase + 4'd1;
         end else if (en) begin
            prescaler <= prescaler + 16'd1;
         end

         // ready_q low means pending_val holds an unapplied value.
         if (wrap && !ready_q) begin
            active_val <= pending_val;
         end
         if (accept) begin
            pending_val <= load.load_data;
            ready_q     <= 1'b0;
         end else if (wrap) begin
            ready_q     <= 1'b1;
         end

         frame_done_q <= wrap;

         if (en) begin
            an_q  <= an_nxt;
            seg_q <= glyph;
         end else begin
            an_q  <= 4'hF;
            seg_q <= 7'b1111111;
         end
      end
   end

   assign load.load_ready = ready_q;
   assign an0             = an_q[0];
   assign an1             = an_q[1];
   assign an2             = an_q[2];
   assign an3             = an_q[3];
   assign seg             = seg_q;
   assign frame_done      = frame_done_q;

endmodule
